// File: rtl/booth_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_sequencer
// Description : Front-end for a Booth ASMD multiplier. Operand pairs are
//               buffered in a small FIFO and issued one at a time with a
//               single-cycle start pulse. The product is returned through a
//               valid/ready result register. A watchdog converts a hung
//               multiplier into an error result so the queue keeps moving.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          clock, rising edge
//   reset_i        asynchronous reset, active high
//   in_valid_i     operand pair offered
//   in_ready_o     FIFO can accept (not full)
//   in_a_i/in_x_i  signed multiplicand / multiplier
//   out_valid_o    result register holds a result
//   out_ready_i    consumer accepts the result
//   out_product_o  signed product (2*L_WORD bits)
//   out_err_o      result produced by watchdog timeout (product forced 0)
//   mul_start_o    start pulse to the multiplier
//   mul_a_o/mul_x_o operands to the multiplier, held from issue to capture
//   mul_ready_i    ready from the multiplier
//   mul_product_i  product from the multiplier
//   busy_o         sequencer not idle
//   fifo_level_o   FIFO occupancy, 0..DEPTH
// Configuration
//   SEQ_ZERO_BYPASS_EN : when defined, a head entry with a zero operand is
//                        retired directly into the result register (product
//                        0) without involving the multiplier.
// ============================================================================
module booth_mul_sequencer #(
   parameter int L_WORD  = 4,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 4*L_WORD+8,
   parameter int L_CNT   = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [L_WORD-1:0]        in_a_i,
   input  logic [L_WORD-1:0]        in_x_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [2*L_WORD-1:0]      out_product_o,
   output logic                     out_err_o,
   output logic                     mul_start_o,
   output logic [L_WORD-1:0]        mul_a_o,
   output logic [L_WORD-1:0]        mul_x_o,
   input  logic                     mul_ready_i,
   input  logic [2*L_WORD-1:0]      mul_product_i,
   output logic                     busy_o,
   output logic [$clog2(DEPTH):0]   fifo_level_o
);

   localparam int                 c_AW      = $clog2(DEPTH);
   localparam logic [c_AW:0]      c_FULL    = (c_AW+1)'(DEPTH);
   localparam logic [L_CNT-1:0]   c_TIMEOUT = L_CNT'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [L_WORD-1:0]       mem_a_q [DEPTH];
   logic [L_WORD-1:0]       mem_x_q [DEPTH];
   logic [c_AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [c_AW:0]           level_q;
   logic [L_CNT-1:0]        wd_q, wd_d;
   logic [L_WORD-1:0]       mul_a_q, mul_x_q;
   logic                    out_valid_q, out_err_q;
   logic [2*L_WORD-1:0]     out_product_q;

   logic                    w_full, w_empty, w_push, w_pop, w_out_free;
   logic                    w_load_mul, w_cap, w_cap_err, w_zero_head;
   logic [2*L_WORD-1:0]     w_cap_prod;
   logic [L_WORD-1:0]       w_head_a, w_head_x;

   assign w_full     = (level_q == c_FULL);
   assign w_empty    = (level_q == '0);
   assign w_push     = in_valid_i & ~w_full;
   assign w_out_free = ~out_valid_q | out_ready_i;
   assign w_head_a   = mem_a_q[rd_ptr_q];
   assign w_head_x   = mem_x_q[rd_ptr_q];

`ifdef SEQ_ZERO_BYPASS_EN
   assign w_zero_head = (w_head_a == '0) | (w_head_x == '0);
`else
   assign w_zero_head = 1'b0;
`endif

   // Next-state and control decode
   always_comb begin
      state_d     = state_q;
      wd_d        = wd_q;
      w_pop       = 1'b0;
      w_load_mul  = 1'b0;
      w_cap       = 1'b0;
      w_cap_err   = 1'b0;
      w_cap_prod  = '0;
      mul_start_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Only start work when the result register will be free to take it
            if (!w_empty && w_out_free) begin
               if (w_zero_head) begin
                  w_pop = 1'b1;
                  w_cap = 1'b1;
               end else if (mul_ready_i) begin
                  w_pop      = 1'b1;
                  w_load_mul = 1'b1;
                  state_d    = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            mul_start_o = 1'b1;
            wd_d        = '0;
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            wd_d = wd_q + L_CNT'(1);
            if (mul_ready_i) begin
               w_cap      = 1'b1;
               w_cap_prod = mul_product_i;
               state_d    = S_IDLE;
            end else if (wd_q == c_TIMEOUT) begin
               w_cap     = 1'b1;
               w_cap_err = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         wd_q          <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         mul_a_q       <= '0;
         mul_x_q       <= '0;
         out_valid_q   <= 1'b0;
         out_err_q     <= 1'b0;
         out_product_q <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         if (w_push) wr_ptr_q <= wr_ptr_q + c_AW'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + c_AW'(1);
         case ({w_push, w_pop})
            2'b10:   level_q <= level_q + (c_AW+1)'(1);
            2'b01:   level_q <= level_q - (c_AW+1)'(1);
            default: level_q <= level_q;
         endcase
         if (w_load_mul) begin
            mul_a_q <= w_head_a;
            mul_x_q <= w_head_x;
         end
         // Capture wins over drain so a result can land while the previous one leaves
         if (w_cap) begin
            out_valid_q   <= 1'b1;
            out_product_q <= w_cap_prod;
            out_err_q     <= w_cap_err;
         end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Storage only; validity is tracked by the pointers and level
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         mem_a_q[wr_ptr_q] <= in_a_i;
         mem_x_q[wr_ptr_q] <= in_x_i;
      end
   end

   assign in_ready_o    = ~w_full;
   assign out_valid_o   = out_valid_q;
   assign out_product_o = out_product_q;
   assign out_err_o     = out_err_q;
   assign mul_a_o       = mul_a_q;
   assign mul_x_o       = mul_x_q;
   assign busy_o        = (state_q != S_IDLE);
   assign fifo_level_o  = level_q;

endmodule
`default_nettype wire
